txpippm_step_sequencer: RTL and testbench
=========================================

// Module: txpippm_step_sequencer
// PURPOSE
//  Multi-channel TX phase-interpolator PPM step sequencer for the GT TX datapath.
//  Accepts a step command (channel mask, direction, magnitude, step count, inter-step gap)
//  and emits N spaced TXPIPPMEN pulses to the selected channels.
//  Replaces single-pulse manual stepping; sits in the TXUSRCLK domain beside the GT wrapper.
// PARAMETERS
//  CHANNEL_COUNT   10  number of GT channels driven
//  COUNT_W         8   width of step-count field (max 2^COUNT_W-1 steps/command)
//  INTERVAL_W      8   width of inter-step gap field
//  EN_PULSE_CYCLES 2   TXPIPPMEN high time per step, cycles (>=1)
//  ACC_W           16  phase accumulator width per channel (macro build only)
// PORTS
//  gtwiz_userclk_tx_usrclk_in in  1              TXUSRCLK; sole clock
//  reset_n_in                 in  1              synchronous, active-low reset
//  cmd_valid_in               in  1              command valid
//  cmd_ready_out              out 1              command accepted when valid&ready
//  cmd_sel_in                 in  CHANNEL_COUNT  channel mask
//  cmd_dir_in                 in  1              1=advance, 0=retard (stepsize bit 4)
//  cmd_mag_in                 in  4              step magnitude (stepsize bits 3:0)
//  cmd_count_in               in  COUNT_W        number of steps
//  cmd_interval_in            in  INTERVAL_W     extra low cycles between steps
//  abort_in                   in  1              stop current command
//  busy_out                   out 1              command in progress
//  done_out                   out 1              1-cycle pulse at command end
//  steps_done_out             out COUNT_W        steps issued by last/current command
//  txpippmen_out              out CHANNEL_COUNT  per-channel TXPIPPMEN
//  txpippmovrden_out          out CHANNEL_COUNT  constant 0
//  txpippmsel_out             out CHANNEL_COUNT  constant 1
//  txpippmpd_out              out CHANNEL_COUNT  constant 0
//  txpippmstepsize_out        out CHANNEL_COUNT*5 {dir,mag} replicated per channel
//  phase_acc_out              out CHANNEL_COUNT*ACC_W signed net phase per channel (macro only)
//  acc_clr_in                 in  1              clear all accumulators (macro only)
// BEHAVIOUR
//  - Reset (reset_n_in=0 at clock edge): state IDLE; txpippmen_out=0, stepsize=0, busy=0,
//    done=0, steps_done=0, latched cmd fields=0, accumulators=0. Reset wins over everything.
//  - cmd_ready_out = (state==IDLE); registered outputs only, no comb path cmd->txpippmen.
//  - Accept: latch sel,dir,mag,count,interval; stepsize_out updates the cycle after accept and
//    holds until the next accept. steps_done clears to 0 on accept.
//  - FSM: IDLE -> PULSE (count!=0) | DONE (count==0).
//    PULSE: txpippmen_out = sel_latched for exactly EN_PULSE_CYCLES cycles, first high cycle
//      is the cycle after accept (or after GAP); at last cycle steps_done++ ;
//      -> DONE if steps_done reaches count or abort seen during pulse, else -> GAP.
//    GAP: en low for interval+1 cycles (min 1 low cycle); -> PULSE; abort -> DONE next cycle.
//    DONE: 1 cycle, done_out=1, busy=0 next; -> IDLE.
//  - busy_out=1 in PULSE/GAP/DONE. Pulses never truncated: abort in PULSE completes it.
//  - abort_in ignored in IDLE/DONE; abort and cmd_valid in IDLE: command accepted.
//  - Step period = EN_PULSE_CYCLES + interval + 1 cycles; count=max gives 2^COUNT_W-1 steps.
//  - sel=0 command: FSM runs normally, no en toggles, steps_done still counts.
// CONFIGURATION
//  - TXPIPPM_PHASE_ACC_EN defined: per channel, on each completed pulse for selected channels,
//    acc += dir ? mag : -mag, saturating at signed ACC_W limits; acc_clr_in zeroes all
//    (clear wins over same-cycle update). Not defined: ports phase_acc_out/acc_clr_in absent,
//    no accumulator logic.
// STRUCTURE
//  - Package txpippm_pkg: FSM state encoding (IDLE,PULSE,GAP,DONE), STEPSIZE_W=5,
//    MAG_W=4, DIR_BIT=4 constants.
//  - Sub-module txpippm_phase_acc: one saturating signed accumulator, generated per channel
//    under the macro.
// TESTING
//  1. Reset: hold reset_n_in=0 5 cycles with cmd_valid=1 -> all outputs 0, ready=0 then 1.
//  2. sel=10'h005,dir=1,mag=3,count=4,interval=2 -> ch0/ch2 en high 2 cyc, low 3 cyc, x4;
//     stepsize=5'b10011 all ch; done 1 cyc after 4th pulse; steps_done=4.
//  3. count=0 -> no en activity, done_out one cycle after accept.
//  4. count=10, abort mid-GAP after 3rd step -> done next cycle, steps_done=3; abort mid-PULSE
//     of 5th step -> pulse full width, steps_done=5.
//  5. Macro on, ACC_W=8: 200 steps dir=1 mag=15 ch1 -> acc saturates at +127; acc_clr -> 0.
//  6. Back-to-back commands with valid held -> second accepted the cycle after done; reset
//     asserted mid-PULSE -> en drops next edge, state IDLE.

Source files
------------

// File: rtl/txpippm_pkg.sv
// ---------------------------------------------------------------------------
// txpippm_pkg
// Shared constants and FSM state encoding for the TX phase-interpolator PPM
// step sequencer.
//   STEPSIZE_W : width of the per-channel TXPIPPMSTEPSIZE field ({dir,mag})
//   MAG_W      : width of the step magnitude (stepsize bits 3:0)
//   DIR_BIT    : position of the direction bit inside stepsize
//   state_t    : sequencer FSM states
// ---------------------------------------------------------------------------
package txpippm_pkg;

  localparam int STEPSIZE_W = 5;
  localparam int MAG_W      = 4;
  localparam int DIR_BIT    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/txpippm_phase_acc.sv
// ---------------------------------------------------------------------------
// txpippm_phase_acc
// One saturating signed phase accumulator. Only built when the macro
// TXPIPPM_PHASE_ACC_EN is defined; the default build contains no logic here.
// Ports:
//   clk      : TXUSRCLK
//   rst_n    : synchronous active-low reset
//   clr_in   : zero the accumulator (wins over a same-cycle update)
//   upd_in   : apply one step
//   dir_in   : 1 = add mag, 0 = subtract mag
//   mag_in   : step magnitude
//   acc_out  : signed accumulated phase
// ---------------------------------------------------------------------------
`ifdef TXPIPPM_PHASE_ACC_EN
module txpippm_phase_acc
  import txpippm_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_in,
  input  logic                    upd_in,
  input  logic                    dir_in,
  input  logic [MAG_W-1:0]        mag_in,
  output logic signed [ACC_W-1:0] acc_out
);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W:0]   delta;
  logic signed [ACC_W:0]   sum;

  always_comb begin
    delta = signed'({{(ACC_W+1-MAG_W){1'b0}}, mag_in});
    if (!dir_in) begin
      delta = -delta;
    end
    // One guard bit: a mismatch between the two top bits means overflow.
    sum   = {acc_q[ACC_W-1], acc_q} + delta;
    acc_d = acc_q;
    if (clr_in) begin
      acc_d = '0;
    end else if (upd_in) begin
      if (sum[ACC_W] != sum[ACC_W-1]) begin
        acc_d = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_out = acc_q;

endmodule
`endif

// File: rtl/txpippm_step_sequencer.sv
// ---------------------------------------------------------------------------
// txpippm_step_sequencer
// Multi-channel TX phase-interpolator PPM step sequencer (TXUSRCLK domain).
// Takes one step command and emits cmd_count spaced TXPIPPMEN pulses of
// EN_PULSE_CYCLES cycles each to the selected channels, with
// cmd_interval+1 low cycles between pulses.
//
// Optional feature macro: TXPIPPM_PHASE_ACC_EN adds a per-channel saturating
// phase accumulator (ports phase_acc_out / acc_clr_in, parameter ACC_W).
//
// Ports:
//   gtwiz_userclk_tx_usrclk_in : sole clock
//   reset_n_in                 : synchronous active-low reset
//   cmd_valid_in/cmd_ready_out : command handshake
//   cmd_sel_in/dir/mag/count/interval : command fields
//   abort_in                   : stop after the current pulse / gap cycle
//   busy_out, done_out, steps_done_out : status
//   txpippm*_out               : GT TXPIPPM control pins
//   state_dbg_out              : current FSM state
//
// Handshake: a command transfers on a clock edge where cmd_valid_in and
// cmd_ready_out are both high; ready is high only in IDLE and out of reset,
// and valid may be held across any number of cycles without side effects.
// ---------------------------------------------------------------------------
module txpippm_step_sequencer
  import txpippm_pkg::*;
#(
  parameter int CHANNEL_COUNT   = 10,
  parameter int COUNT_W         = 8,
  parameter int INTERVAL_W      = 8,
  parameter int EN_PULSE_CYCLES = 2
`ifdef TXPIPPM_PHASE_ACC_EN
  ,
  parameter int ACC_W           = 16
`endif
) (
  input  logic                             gtwiz_userclk_tx_usrclk_in,
  input  logic                             reset_n_in,
  input  logic                             cmd_valid_in,
  output logic                             cmd_ready_out,
  input  logic [CHANNEL_COUNT-1:0]         cmd_sel_in,
  input  logic                             cmd_dir_in,
  input  logic [MAG_W-1:0]                 cmd_mag_in,
  input  logic [COUNT_W-1:0]               cmd_count_in,
  input  logic [INTERVAL_W-1:0]            cmd_interval_in,
  input  logic                             abort_in,
  output logic                             busy_out,
  output logic                             done_out,
  output logic [COUNT_W-1:0]               steps_done_out,
  output logic [CHANNEL_COUNT-1:0]         txpippmen_out,
  output logic [CHANNEL_COUNT-1:0]         txpippmovrden_out,
  output logic [CHANNEL_COUNT-1:0]         txpippmsel_out,
  output logic [CHANNEL_COUNT-1:0]         txpippmpd_out,
  output logic [CHANNEL_COUNT*STEPSIZE_W-1:0] txpippmstepsize_out,
`ifdef TXPIPPM_PHASE_ACC_EN
  output logic [CHANNEL_COUNT*ACC_W-1:0]   phase_acc_out,
  input  logic                             acc_clr_in,
`endif
  output logic [1:0]                       state_dbg_out
);

  localparam int PC_W = $clog2(EN_PULSE_CYCLES + 1);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(EN_PULSE_CYCLES - 1);

  state_t                    state_q, state_d;
  logic [CHANNEL_COUNT-1:0]  sel_q, sel_d;
  logic [STEPSIZE_W-1:0]     stepsize_q, stepsize_d;
  logic [COUNT_W-1:0]        count_q, count_d;
  logic [INTERVAL_W-1:0]     interval_q, interval_d;
  logic [COUNT_W-1:0]        steps_q, steps_d;
  logic [PC_W-1:0]           pcnt_q, pcnt_d;
  logic [INTERVAL_W-1:0]     gcnt_q, gcnt_d;
  logic                      abort_seen_q, abort_seen_d;
  logic [CHANNEL_COUNT-1:0]  en_q, en_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      step_fire;
  logic [COUNT_W-1:0]        steps_inc;

  assign cmd_ready_out = (state_q == ST_IDLE) && reset_n_in;
  assign steps_inc     = steps_q + COUNT_W'(1);

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    stepsize_d   = stepsize_q;
    count_d      = count_q;
    interval_d   = interval_q;
    steps_d      = steps_q;
    pcnt_d       = pcnt_q;
    gcnt_d       = gcnt_q;
    abort_seen_d = abort_seen_q;
    en_d         = '0;
    step_fire    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_in && cmd_ready_out) begin
          sel_d        = cmd_sel_in;
          stepsize_d   = {cmd_dir_in, cmd_mag_in};
          count_d      = cmd_count_in;
          interval_d   = cmd_interval_in;
          steps_d      = '0;
          pcnt_d       = '0;
          abort_seen_d = 1'b0;
          if (cmd_count_in != '0) begin
            state_d = ST_PULSE;
            en_d    = cmd_sel_in;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_PULSE: begin
        // An abort during a pulse is remembered; the pulse always completes.
        if (abort_in) begin
          abort_seen_d = 1'b1;
        end
        if (pcnt_q == PC_LAST) begin
          step_fire = 1'b1;
          pcnt_d    = '0;
          if ((steps_inc == count_q) || abort_seen_q || abort_in) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_GAP;
            gcnt_d  = interval_q;
          end
        end else begin
          pcnt_d = pcnt_q + PC_W'(1);
          en_d   = sel_q;
        end
      end
      ST_GAP: begin
        if (abort_in) begin
          state_d = ST_DONE;
        end else if (gcnt_q == '0) begin
          state_d = ST_PULSE;
          en_d    = sel_q;
        end else begin
          gcnt_d = gcnt_q - INTERVAL_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (step_fire) begin
      steps_d = steps_inc;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge gtwiz_userclk_tx_usrclk_in) begin
    if (!reset_n_in) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      stepsize_q   <= '0;
      count_q      <= '0;
      interval_q   <= '0;
      steps_q      <= '0;
      pcnt_q       <= '0;
      gcnt_q       <= '0;
      abort_seen_q <= 1'b0;
      en_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      stepsize_q   <= stepsize_d;
      count_q      <= count_d;
      interval_q   <= interval_d;
      steps_q      <= steps_d;
      pcnt_q       <= pcnt_d;
      gcnt_q       <= gcnt_d;
      abort_seen_q <= abort_seen_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy_out            = busy_q;
  assign done_out            = done_q;
  assign steps_done_out      = steps_q;
  assign txpippmen_out       = en_q;
  assign txpippmovrden_out   = '0;
  assign txpippmsel_out      = '1;
  assign txpippmpd_out       = '0;
  assign txpippmstepsize_out = {CHANNEL_COUNT{stepsize_q}};
  assign state_dbg_out       = state_q;

`ifdef TXPIPPM_PHASE_ACC_EN
  for (genvar i = 0; i < CHANNEL_COUNT; i++) begin : g_acc
    txpippm_phase_acc #(
      .ACC_W (ACC_W)
    ) u_acc (
      .clk     (gtwiz_userclk_tx_usrclk_in),
      .rst_n   (reset_n_in),
      .clr_in  (acc_clr_in),
      .upd_in  (step_fire && sel_q[i]),
      .dir_in  (stepsize_q[DIR_BIT]),
      .mag_in  (stepsize_q[MAG_W-1:0]),
      .acc_out (phase_acc_out[i*ACC_W +: ACC_W])
    );
  end
`endif

endmodule

// File: tb/tb_txpippm_step_sequencer.sv
module tb_txpippm_step_sequencer;

  localparam int CH = 10;
  localparam int CW = 8;
  localparam int IW = 8;
  localparam int P  = 2;
  localparam int AW = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n_in;
  logic           cmd_valid_in;
  logic           cmd_ready_out;
  logic [CH-1:0]  cmd_sel_in;
  logic           cmd_dir_in;
  logic [3:0]     cmd_mag_in;
  logic [CW-1:0]  cmd_count_in;
  logic [IW-1:0]  cmd_interval_in;
  logic           abort_in;
  logic           busy_out;
  logic           done_out;
  logic [CW-1:0]  steps_done_out;
  logic [CH-1:0]  txpippmen_out;
  logic [CH-1:0]  txpippmovrden_out;
  logic [CH-1:0]  txpippmsel_out;
  logic [CH-1:0]  txpippmpd_out;
  logic [CH*5-1:0] txpippmstepsize_out;
  logic [1:0]     state_dbg_out;
`ifdef TXPIPPM_PHASE_ACC_EN
  logic [CH*AW-1:0] phase_acc_out;
  logic             acc_clr_in;
`endif

  txpippm_step_sequencer #(
    .CHANNEL_COUNT   (CH),
    .COUNT_W         (CW),
    .INTERVAL_W      (IW),
    .EN_PULSE_CYCLES (P)
`ifdef TXPIPPM_PHASE_ACC_EN
    ,
    .ACC_W           (AW)
`endif
  ) dut (
    .gtwiz_userclk_tx_usrclk_in (clk),
    .reset_n_in          (reset_n_in),
    .cmd_valid_in        (cmd_valid_in),
    .cmd_ready_out       (cmd_ready_out),
    .cmd_sel_in          (cmd_sel_in),
    .cmd_dir_in          (cmd_dir_in),
    .cmd_mag_in          (cmd_mag_in),
    .cmd_count_in        (cmd_count_in),
    .cmd_interval_in     (cmd_interval_in),
    .abort_in            (abort_in),
    .busy_out            (busy_out),
    .done_out            (done_out),
    .steps_done_out      (steps_done_out),
    .txpippmen_out       (txpippmen_out),
    .txpippmovrden_out   (txpippmovrden_out),
    .txpippmsel_out      (txpippmsel_out),
    .txpippmpd_out       (txpippmpd_out),
    .txpippmstepsize_out (txpippmstepsize_out),
`ifdef TXPIPPM_PHASE_ACC_EN
    .phase_acc_out       (phase_acc_out),
    .acc_clr_in          (acc_clr_in),
`endif
    .state_dbg_out       (state_dbg_out)
  );

  // scoreboard
  int checks   = 0;
  int failures = 0;
  logic [11:0] exp_q[$];   // {busy, done, en[CH-1:0]} per cycle

  typedef struct {
    logic [CH-1:0] sel;
    logic          dir;
    logic [3:0]    mag;
    int            count;
    int            interval;
    int            abort_at;
    int            exp_steps;
  } cmd_vec_t;

  cmd_vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of one command: expected per-cycle outputs from the
  // first cycle after accept through the done cycle.
  task automatic build_exp(input logic [CH-1:0] sel, input int count, input int interval,
                           input int abort_at);
    int  cyc;
    int  steps;
    bit  stop;
    bit  ab;
    cyc = 0; steps = 0; stop = 0;
    while (!stop && steps < count) begin
      ab = 0;
      for (int p = 0; p < P; p++) begin
        if (cyc == abort_at) ab = 1;
        exp_q.push_back({2'b10, sel});
        cyc++;
      end
      steps++;
      if (ab || steps == count) begin
        stop = 1;
      end else begin
        for (int g = 0; g <= interval; g++) begin
          exp_q.push_back({2'b10, {CH{1'b0}}});
          if (cyc == abort_at) begin
            cyc++;
            stop = 1;
            break;
          end
          cyc++;
        end
      end
    end
    exp_q.push_back({2'b11, {CH{1'b0}}});
  endtask

  task automatic run_cmd(input cmd_vec_t v);
    int n;
    int cyc;
    logic [11:0] e;
    logic [CH*5-1:0] exp_ss;
    for (int i = 0; i < CH; i++) exp_ss[i*5 +: 5] = {v.dir, v.mag};
    @(negedge clk);
    cmd_sel_in      = v.sel;
    cmd_dir_in      = v.dir;
    cmd_mag_in      = v.mag;
    cmd_count_in    = CW'(v.count);
    cmd_interval_in = IW'(v.interval);
    cmd_valid_in    = 1'b1;
    n = 0;
    while (!cmd_ready_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) chk("ready_timeout", 64'(cmd_ready_out), 64'd1);
    build_exp(v.sel, v.count, v.interval, v.abort_at);
    @(posedge clk);
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      cmd_valid_in = 1'b0;
      e = exp_q.pop_front();
      chk("wave_busy_done_en", 64'({busy_out, done_out, txpippmen_out}), 64'(e));
      abort_in = (cyc == v.abort_at);
      cyc++;
    end
    @(negedge clk);
    abort_in = 1'b0;
    chk("idle_busy", 64'(busy_out), 64'd0);
    chk("idle_done", 64'(done_out), 64'd0);
    chk("idle_ready", 64'(cmd_ready_out), 64'd1);
    chk("steps_done", 64'(steps_done_out), 64'(v.exp_steps));
    chk("stepsize", 64'(txpippmstepsize_out), 64'(exp_ss));
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(done_out), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_in      = 1'b0;
    cmd_valid_in    = 1'b1;
    cmd_sel_in      = 10'h3FF;
    cmd_dir_in      = 1'b1;
    cmd_mag_in      = 4'hF;
    cmd_count_in    = 8'd3;
    cmd_interval_in = 8'd1;
    abort_in        = 1'b0;
`ifdef TXPIPPM_PHASE_ACC_EN
    acc_clr_in      = 1'b0;
`endif

    // reset held 5 cycles with valid high
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_en", 64'(txpippmen_out), 64'd0);
      chk("rst_busy_done", 64'({busy_out, done_out}), 64'd0);
      chk("rst_steps", 64'(steps_done_out), 64'd0);
      chk("rst_stepsize", 64'(txpippmstepsize_out), 64'd0);
      chk("rst_ready", 64'(cmd_ready_out), 64'd0);
      chk("rst_state", 64'(state_dbg_out), 64'd0);
    end
    chk("ovrden_const", 64'(txpippmovrden_out), 64'd0);
    chk("sel_const", 64'(txpippmsel_out), 64'h3FF);
    chk("pd_const", 64'(txpippmpd_out), 64'd0);
`ifdef TXPIPPM_PHASE_ACC_EN
    chk("rst_acc", 64'(phase_acc_out[63:0]), 64'd0);
`endif
    @(negedge clk);
    cmd_valid_in = 1'b0;
    reset_n_in   = 1'b1;
    #1;
    chk("ready_after_rst", 64'(cmd_ready_out), 64'd1);

    // command table
    vecs[0] = '{10'h005, 1'b1, 4'd3,  4,   2, -1, 4};
    vecs[1] = '{10'h3FF, 1'b0, 4'd9,  0,   0, -1, 0};
    vecs[2] = '{10'h0F0, 1'b1, 4'd5,  10,  2, 13, 3};
    vecs[3] = '{10'h021, 1'b0, 4'd7,  10,  2, 20, 5};
    vecs[4] = '{10'h000, 1'b1, 4'd1,  3,   0, -1, 3};
    vecs[5] = '{10'h200, 1'b1, 4'd15, 1,   5, -1, 1};
    vecs[6] = '{10'h001, 1'b0, 4'd2,  255, 0, -1, 255};
    vecs[7].sel       = CH'($urandom_range(1, 1023));
    vecs[7].dir       = 1'($urandom_range(0, 1));
    vecs[7].mag       = 4'($urandom_range(0, 15));
    vecs[7].count     = int'($urandom_range(1, 6));
    vecs[7].interval  = int'($urandom_range(0, 3));
    vecs[7].abort_at  = -1;
    vecs[7].exp_steps = vecs[7].count;

    for (int i = 0; i < 8; i++) run_cmd(vecs[i]);

    // back-to-back with valid held
    @(negedge clk);
    cmd_sel_in = 10'h003; cmd_dir_in = 1'b1; cmd_mag_in = 4'd4;
    cmd_count_in = 8'd1; cmd_interval_in = 8'd0; cmd_valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_sel_in = 10'h300; cmd_dir_in = 1'b0; cmd_mag_in = 4'd2; cmd_count_in = 8'd2;
    chk("b2b_a_en0", 64'(txpippmen_out), 64'h003);
    @(negedge clk);
    chk("b2b_a_en1", 64'(txpippmen_out), 64'h003);
    @(negedge clk);
    chk("b2b_a_done", 64'({done_out, cmd_ready_out}), 64'b10);
    @(negedge clk);
    chk("b2b_idle_ready", 64'({done_out, cmd_ready_out, txpippmen_out}), 64'({2'b01, 10'h000}));
    @(negedge clk);
    cmd_valid_in = 1'b0;
    chk("b2b_b_en", 64'({busy_out, txpippmen_out}), 64'({1'b1, 10'h300}));
    wait_done("b2b_b_done");
    @(negedge clk);
    chk("b2b_b_steps", 64'(steps_done_out), 64'd2);

    // abort together with valid in IDLE: command still accepted
    @(negedge clk);
    cmd_sel_in = 10'h010; cmd_count_in = 8'd2; cmd_interval_in = 8'd1;
    cmd_valid_in = 1'b1; abort_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid_in = 1'b0; abort_in = 1'b0;
    chk("idle_abort_accept", 64'({busy_out, txpippmen_out}), 64'({1'b1, 10'h010}));
    wait_done("idle_abort_done");
    @(negedge clk);
    chk("idle_abort_steps", 64'(steps_done_out), 64'd2);

    // reset mid-pulse
    @(negedge clk);
    cmd_sel_in = 10'h0FF; cmd_count_in = 8'd5; cmd_valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid_in = 1'b0;
    chk("mid_rst_en_before", 64'(txpippmen_out), 64'h0FF);
    reset_n_in = 1'b0;
    @(negedge clk);
    chk("mid_rst_en", 64'(txpippmen_out), 64'd0);
    chk("mid_rst_busy", 64'(busy_out), 64'd0);
    chk("mid_rst_state", 64'(state_dbg_out), 64'd0);
    chk("mid_rst_stepsize", 64'(txpippmstepsize_out), 64'd0);
    reset_n_in = 1'b1;

`ifdef TXPIPPM_PHASE_ACC_EN
    begin
      cmd_vec_t a;
      a = '{10'h002, 1'b1, 4'd15, 200, 0, -1, 200};
      run_cmd(a);
      chk("acc_ch1_sat_pos", 64'(phase_acc_out[AW +: AW]), 64'h7F);
      chk("acc_ch0_zero", 64'(phase_acc_out[0 +: AW]), 64'h00);
      a = '{10'h002, 1'b0, 4'd15, 20, 0, -1, 20};
      run_cmd(a);
      chk("acc_ch1_sat_neg", 64'(phase_acc_out[AW +: AW]), 64'h80);
      @(negedge clk);
      acc_clr_in = 1'b1;
      @(negedge clk);
      acc_clr_in = 1'b0;
      chk("acc_clr", 64'(phase_acc_out[AW +: AW]), 64'h00);
    end
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
